speed_violation_logger: RTL and testbench

SPEED_VIOLATION_LOGGER -- requirements
Module: speed_violation_logger

---
 rtl/speed_violation_logger.sv | 79 +++++++
 tb/tb_speed_violation_logger.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/speed_violation_logger.sv
// Logs the first over-limit record of each car ID into a FIFO for a downstream
// consumer, tracking accepted and dropped violations with saturating counters.
module speed_violation_logger #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_speed,
  input  logic [DEPTH-1:0] i_id,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_clear,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [DEPTH-1:0] o_id,
  output logic [WIDTH-1:0] o_speed,
  output logic [15:0]      o_viol_cnt,
  output logic [15:0]      o_drop_cnt
);

  localparam int ENTRIES = 2 ** FIFO_AW;
  localparam int IDS     = 2 ** DEPTH;
  localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

  logic [FIFO_AW:0]         wr_ptr, rd_ptr;
  logic [DEPTH+WIDTH-1:0]   mem [ENTRIES];
  logic [DEPTH+WIDTH-1:0]   head;
  logic [IDS-1:0]           reported;
  logic [15:0]              viol_cnt, drop_cnt;
  logic                     empty, full, pop, seen, viol, push, drop;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop   = !empty && i_ready;

  // A same-cycle clear means the ID is judged against an empty table.
  assign seen  = reported[i_id] && !i_clear;
  assign viol  = (i_speed != '0) && (i_speed > i_limit) && !seen;
  assign push  = viol && (!full || pop);
  assign drop  = viol && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      reported <= '0;
      viol_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (i_clear) reported <= '0;
      if (push) begin
        reported[i_id] <= 1'b1;
        viol_cnt       <= sat_inc(viol_cnt);
      end
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // Storage holds no control state, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {i_id, i_speed};
  end

  assign head       = mem[rd_ptr[FIFO_AW-1:0]];
  assign o_valid    = !empty;
  assign o_id       = empty ? '0 : head[WIDTH +: DEPTH];
  assign o_speed    = empty ? '0 : head[WIDTH-1:0];
  assign o_viol_cnt = viol_cnt;
  assign o_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_speed_violation_logger.sv
// Directed and randomized checks of speed_violation_logger against a
// queue-based reference model evaluated once per clock.
module tb_speed_violation_logger;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_speed, i_id, i_limit;
  logic       i_clear, i_ready;
  logic       o_valid;
  logic [7:0] o_id, o_speed;
  logic [15:0] o_viol_cnt, o_drop_cnt;

  always #5 clk = ~clk;

  speed_violation_logger #(.WIDTH(8), .DEPTH(8), .FIFO_AW(4)) dut (
    .clk(clk), .rst(rst), .i_speed(i_speed), .i_id(i_id), .i_limit(i_limit),
    .i_clear(i_clear), .i_ready(i_ready), .o_valid(o_valid), .o_id(o_id),
    .o_speed(o_speed), .o_viol_cnt(o_viol_cnt), .o_drop_cnt(o_drop_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_tbl [256];
  logic [15:0] m_q [$];
  int          m_viol = 0;
  int          m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit pop, viol, was_full;
    if (rst) begin
      for (int k = 0; k < 256; k++) m_tbl[k] = 0;
      m_q.delete();
      m_viol = 0;
      m_drop = 0;
      return;
    end
    was_full = (m_q.size() == 16);
    pop      = (m_q.size() > 0) && i_ready;
    if (i_clear) for (int k = 0; k < 256; k++) m_tbl[k] = 0;
    viol = (i_speed != 0) && (i_speed > i_limit) && !m_tbl[i_id];
    if (pop) void'(m_q.pop_front());
    if (viol) begin
      if (!was_full || pop) begin
        m_q.push_back({i_id, i_speed});
        m_tbl[i_id] = 1;
        if (m_viol < 65535) m_viol++;
      end else if (m_drop < 65535) m_drop++;
    end
  endtask

  task automatic compare_all();
    chk("valid", o_valid, m_q.size() > 0);
    chk("id",    o_id,    m_q.size() > 0 ? m_q[0][15:8] : 8'd0);
    chk("speed", o_speed, m_q.size() > 0 ? m_q[0][7:0]  : 8'd0);
    chk("viol_cnt", o_viol_cnt, m_viol);
    chk("drop_cnt", o_drop_cnt, m_drop);
  endtask

  task automatic cycle(input logic r, input logic [7:0] spd, input logic [7:0] id,
                       input logic clr, input logic rdy);
    @(negedge clk);
    rst = r; i_speed = spd; i_id = id; i_clear = clr; i_ready = rdy;
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; i_speed = '0; i_id = '0; i_limit = 8'd60; i_clear = 1'b0; i_ready = 1'b0;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 90, 3, 0, 1);
    chk("reset_valid", o_valid, 0);

    // Single violation, immediate accept
    cycle(0, 80, 5, 0, 1);
    chk("single_id", o_id, 5);
    chk("single_speed", o_speed, 80);
    cycle(0, 0, 0, 0, 1);
    chk("single_drained", o_valid, 0);
    chk("single_cnt", o_viol_cnt, 1);

    // Repeat suppression, clear, equal-to-limit
    cycle(1, 0, 0, 0, 0);
    cycle(0, 80, 5, 0, 0);
    cycle(0, 90, 5, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 95, 5, 0, 0);
    cycle(0, 60, 7, 0, 0);
    chk("clear_cnt", o_viol_cnt, 2);
    chk("clear_head", o_speed, 80);
    cycle(0, 0, 0, 0, 1);
    chk("clear_second", o_speed, 95);
    cycle(0, 0, 0, 0, 1);
    chk("clear_empty", o_valid, 0);

    // Fill, overflow drops, drain, re-log dropped IDs
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) cycle(0, 100, 8'(10 + k), 0, 0);
    cycle(0, 101, 30, 0, 0);
    cycle(0, 102, 31, 0, 0);
    chk("full_drop", o_drop_cnt, 2);
    chk("full_viol", o_viol_cnt, 16);
    for (int k = 0; k < 16; k++) cycle(0, 0, 0, 0, 1);
    cycle(0, 103, 30, 0, 1);
    cycle(0, 104, 31, 0, 1);
    chk("relog_id", o_id, 31);
    chk("relog_cnt", o_viol_cnt, 18);

    // Full with simultaneous pop accepts push
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) cycle(0, 100, 8'(40 + k), 0, 0);
    cycle(0, 120, 99, 0, 1);
    chk("swap_drop", o_drop_cnt, 0);
    chk("swap_viol", o_viol_cnt, 17);
    for (int k = 0; k < 17; k++) cycle(0, 0, 0, 0, 1);

    // Reset mid-stream overrides a pending violation
    for (int k = 0; k < 3; k++) cycle(0, 100, 8'(60 + k), 0, 0);
    cycle(1, 100, 70, 0, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_viol", o_viol_cnt, 0);
    cycle(0, 100, 60, 0, 1);
    chk("rst_relog", o_id, 60);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) i_limit = 8'($urandom_range(20, 120));
      cycle($urandom_range(0, 99) == 0,
            ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 150)),
            8'($urandom_range(0, 40)),
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 2) != 0 ? (n % 400 < 300) : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
